// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM mode encodings and default widths
package pwm_pkg;

  localparam int PWM_CNT_W = 16;
  localparam int PWM_PSC_W = 4;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_UPDOWN = 2'b10,
    MODE_UP_ALT = 2'b11
  } mode_t;

endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - power-of-two prescaler producing count steps and tick pulses
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PSC_W = PWM_PSC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_q,
  input  logic             clear,
  input  logic [PSC_W-1:0] psc_exp,
  output logic             step,
  output logic             tick
);

  localparam int PW = (1 << PSC_W) - 1;
  localparam logic [PSC_W-1:0] SHIFT_MAX = PSC_W'(PW);

  logic [PW-1:0] psc_q;
  logic [PW-1:0] limit;

  // Terminal count is 2^E-1: an all-ones mask of E bits.
  always_comb begin
    limit = {PW{1'b1}} >> (SHIFT_MAX - psc_exp);
  end

  assign step = en_q & ~clear & (psc_q == limit);

  // Prescale counter and registered tick; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q <= '0;
      tick  <= 1'b0;
    end else if (clear) begin
      psc_q <= '0;
      tick  <= 1'b0;
    end else if (en_q) begin
      psc_q <= step ? '0 : psc_q + PW'(1);
      tick  <= step;
    end else begin
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - shadowed up/down/centre PWM time base with one-shot and events
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W,
  parameter int PSC_W = PWM_PSC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             count_reset,
  input  logic [1:0]       mode,
  input  logic             one_shot,
  input  logic [CNT_W-1:0] period,
  input  logic [PSC_W-1:0] prescale,
  output logic [CNT_W-1:0] count_val,
  output logic             dir,
  output logic             tick,
  output logic             ovf,
  output logic             udf,
  output logic             running
);

  logic [CNT_W-1:0] per_q;
  logic [PSC_W-1:0] psc_exp_q;
  mode_t            mode_q;
  logic             done_q;
  logic             fresh_q;   // no tick yet since clear: a down-mode 0->P load is a start, not a wrap
  logic             step;
  logic [CNT_W-1:0] cnt_d;
  logic             dir_d;
  logic             ovf_d;
  logic             udf_d;
  logic             upd_evt;

  assign running = rst_n & en & ~done_q;

  pwm_prescaler #(.PSC_W(PSC_W)) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_q    (running),
    .clear   (count_reset),
    .psc_exp (psc_exp_q),
    .step    (step),
    .tick    (tick)
  );

  // Next count/direction and wrap events for a step, per active mode.
  always_comb begin
    cnt_d = count_val;
    dir_d = dir;
    ovf_d = 1'b0;
    udf_d = 1'b0;
    case (mode_q)
      MODE_DOWN: begin
        dir_d = 1'b0;
        if (count_val == '0) begin
          // Shadow reloads on this same edge, so reload with the incoming period.
          cnt_d = period;
          udf_d = 1'b1;
        end else begin
          cnt_d = count_val - CNT_W'(1);
        end
      end
      MODE_UPDOWN: begin
        if (per_q == '0) begin
          cnt_d = '0;
          udf_d = 1'b1;
          dir_d = 1'b1;
        end else if (dir) begin
          if (count_val >= per_q - CNT_W'(1)) begin
            cnt_d = per_q;
            ovf_d = 1'b1;
            dir_d = 1'b0;
          end else begin
            cnt_d = count_val + CNT_W'(1);
          end
        end else begin
          if (count_val <= CNT_W'(1)) begin
            cnt_d = '0;
            udf_d = 1'b1;
            dir_d = 1'b1;
          end else begin
            cnt_d = count_val - CNT_W'(1);
          end
        end
      end
      default: begin
        dir_d = 1'b1;
        if (count_val >= per_q) begin
          cnt_d = '0;
          ovf_d = 1'b1;
        end else begin
          cnt_d = count_val + CNT_W'(1);
        end
      end
    endcase
  end

  assign upd_evt = ((mode_q == MODE_DOWN) || (mode_q == MODE_UPDOWN)) ? udf_d : ovf_d;

  // Shadow registers: transparent while stopped or cleared, else latched at update events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q     <= '0;
      psc_exp_q <= '0;
      mode_q    <= MODE_UP;
    end else if (!en || count_reset || (step && upd_evt)) begin
      per_q     <= period;
      psc_exp_q <= prescale;
      mode_q    <= mode_t'(mode);
    end
  end

  // Count, direction, event pulses and one-shot completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_val <= '0;
      dir       <= 1'b1;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      done_q    <= 1'b0;
      fresh_q   <= 1'b1;
    end else if (count_reset) begin
      count_val <= '0;
      dir       <= 1'b1;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      done_q    <= 1'b0;
      fresh_q   <= 1'b1;
    end else if (!en) begin
      ovf       <= 1'b0;
      udf       <= 1'b0;
      done_q    <= 1'b0;
    end else if (step) begin
      count_val <= cnt_d;
      dir       <= dir_d;
      ovf       <= ovf_d;
      udf       <= udf_d;
      fresh_q   <= 1'b0;
      if (one_shot && upd_evt && !(fresh_q && mode_q == MODE_DOWN)) begin
        done_q  <= 1'b1;
      end
    end else begin
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_timebase.sv
// tb/tb_pwm_timebase.sv - self-checking bench for pwm_timebase
module tb_pwm_timebase;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        count_reset = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        one_shot = 1'b0;
  logic [15:0] period = 16'd0;
  logic [3:0]  prescale = 4'd0;
  logic [15:0] count_val;
  logic        dir;
  logic        tick;
  logic        ovf;
  logic        udf;
  logic        running;

  int vectors = 0;
  int errs = 0;

  pwm_timebase dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .count_reset (count_reset),
    .mode        (mode),
    .one_shot    (one_shot),
    .period      (period),
    .prescale    (prescale),
    .count_val   (count_val),
    .dir         (dir),
    .tick        (tick),
    .ovf         (ovf),
    .udf         (udf),
    .running     (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          en;
    bit          cr;
    logic [1:0]  mode;
    logic [15:0] per;
    logic [3:0]  psc;
    logic [20:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [20:0] pk(input int c, input bit d, input bit t,
                                     input bit o, input bit u, input bit r);
    return {16'(c), d, t, o, u, r};
  endfunction

  function automatic vec_t mk(input bit e, input bit cr, input logic [1:0] m,
                              input int p, input logic [20:0] x, input string nm);
    vec_t v;
    v.en = e; v.cr = cr; v.mode = m; v.per = 16'(p); v.psc = 4'd0; v.exp = x; v.name = nm;
    return v;
  endfunction

  // Expected outputs c cycles after enabling, from the closed-form period arithmetic.
  function automatic logic [20:0] model(input logic [1:0] m, input int p, input int e,
                                        input bit os, input int c);
    int l, k, tdone, cnt, ph;
    bit tk, ov, ud, dr, run;
    l = 1 << e;
    case (m)
      2'b01:   tdone = p + 2;
      2'b10:   tdone = (p == 0) ? 1 : 2 * p;
      default: tdone = p + 1;
    endcase
    k = c / l;
    tk = (c % l) == 0;
    run = 1'b1;
    if (os && k >= tdone) begin
      run = 1'b0;
      if (k > tdone) begin
        k = tdone;
        tk = 1'b0;
      end
    end
    ov = 1'b0; ud = 1'b0; dr = 1'b1;
    case (m)
      2'b01: begin
        cnt = (p + 1 - (k % (p + 1))) % (p + 1);
        if (k > 0) dr = 1'b0;
        ud = tk && (cnt == p);
      end
      2'b10: begin
        if (p == 0) begin
          cnt = 0;
          ud = tk;
        end else begin
          ph = k % (2 * p);
          cnt = (ph <= p) ? ph : 2 * p - ph;
          dr = ph < p;
          ov = tk && (ph == p);
          ud = tk && (ph == 0);
        end
      end
      default: begin
        cnt = k % (p + 1);
        ov = tk && (cnt == 0);
      end
    endcase
    return pk(cnt, dr, tk, ov, ud, run);
  endfunction

  task automatic check(input string nm, input logic [20:0] x);
    logic [20:0] got;
    got = {count_val, dir, tick, ovf, udf, running};
    vectors++;
    if (got !== x) begin
      errs++;
      $display("FAIL %s: got count=%0d dir,tick,ovf,udf,running=%b required count=%0d dir,tick,ovf,udf,running=%b",
               nm, got[20:5], got[4:0], x[20:5], x[4:0]);
    end
  endtask

  task automatic step(input bit e, input bit cr, input logic [1:0] m, input bit os,
                      input int p, input int ps, input logic [20:0] x, input string nm);
    @(negedge clk);
    en = e; count_reset = cr; mode = m; one_shot = os;
    period = 16'(p); prescale = 4'(ps);
    @(posedge clk);
    #1;
    check(nm, x);
  endtask

  task automatic run_cfg(input logic [1:0] m, input int p, input int e, input bit os,
                         input int n, input string nm);
    step(1'b0, 1'b1, m, os, p, e, pk(0, 1, 0, 0, 0, 0), {nm, "_clr"});
    for (int c = 1; c <= n; c++) begin
      step(1'b1, 1'b0, m, os, p, e, model(m, p, e, os, c), nm);
    end
  endtask

  initial begin
    // Up P=3 E=0
    vecs.push_back(mk(0, 1, 2'b00, 3, pk(0, 1, 0, 0, 0, 0), "up_clr"));
    vecs.push_back(mk(1, 0, 2'b00, 3, pk(1, 1, 1, 0, 0, 1), "up_1"));
    vecs.push_back(mk(1, 0, 2'b00, 3, pk(2, 1, 1, 0, 0, 1), "up_2"));
    vecs.push_back(mk(1, 0, 2'b00, 3, pk(3, 1, 1, 0, 0, 1), "up_3"));
    vecs.push_back(mk(1, 0, 2'b00, 3, pk(0, 1, 1, 1, 0, 1), "up_wrap"));
    vecs.push_back(mk(1, 0, 2'b00, 3, pk(1, 1, 1, 0, 0, 1), "up_1b"));
    // Up-down P=3 E=0
    vecs.push_back(mk(0, 1, 2'b10, 3, pk(0, 1, 0, 0, 0, 0), "ud_clr"));
    vecs.push_back(mk(1, 0, 2'b10, 3, pk(1, 1, 1, 0, 0, 1), "ud_1"));
    vecs.push_back(mk(1, 0, 2'b10, 3, pk(2, 1, 1, 0, 0, 1), "ud_2"));
    vecs.push_back(mk(1, 0, 2'b10, 3, pk(3, 0, 1, 1, 0, 1), "ud_top"));
    vecs.push_back(mk(1, 0, 2'b10, 3, pk(2, 0, 1, 0, 0, 1), "ud_2d"));
    vecs.push_back(mk(1, 0, 2'b10, 3, pk(1, 0, 1, 0, 0, 1), "ud_1d"));
    vecs.push_back(mk(1, 0, 2'b10, 3, pk(0, 1, 1, 0, 1, 1), "ud_bottom"));
    vecs.push_back(mk(1, 0, 2'b10, 3, pk(1, 1, 1, 0, 0, 1), "ud_1u"));
    // Mode 11 as up, P=1, with an en=0 hold
    vecs.push_back(mk(0, 1, 2'b11, 1, pk(0, 1, 0, 0, 0, 0), "m3_clr"));
    vecs.push_back(mk(1, 0, 2'b11, 1, pk(1, 1, 1, 0, 0, 1), "m3_1"));
    vecs.push_back(mk(1, 0, 2'b11, 1, pk(0, 1, 1, 1, 0, 1), "m3_wrap"));
    vecs.push_back(mk(0, 0, 2'b11, 1, pk(0, 1, 0, 0, 0, 0), "m3_hold"));
    vecs.push_back(mk(1, 0, 2'b11, 1, pk(1, 1, 1, 0, 0, 1), "m3_resume"));
    // Down with P=0: udf every tick
    vecs.push_back(mk(0, 1, 2'b01, 0, pk(0, 1, 0, 0, 0, 0), "dn0_clr"));
    vecs.push_back(mk(1, 0, 2'b01, 0, pk(0, 0, 1, 0, 1, 1), "dn0_a"));
    vecs.push_back(mk(1, 0, 2'b01, 0, pk(0, 0, 1, 0, 1, 1), "dn0_b"));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", pk(0, 1, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].cr, vecs[i].mode, 1'b0, vecs[i].per, vecs[i].psc,
           vecs[i].exp, vecs[i].name);
    end

    // Up P=2 E=2: step every 4 cycles, ovf every 12
    run_cfg(2'b00, 2, 2, 1'b0, 26, "up_psc");

    // Period write mid-run only takes effect at the wrap
    step(1'b0, 1'b1, 2'b00, 1'b0, 10, 0, pk(0, 1, 0, 0, 0, 0), "shadow_clr");
    for (int c = 1; c <= 7; c++) step(1'b1, 1'b0, 2'b00, 1'b0, 10, 0, pk(c, 1, 1, 0, 0, 1), "shadow_run");
    for (int c = 8; c <= 10; c++) step(1'b1, 1'b0, 2'b00, 1'b0, 4, 0, pk(c, 1, 1, 0, 0, 1), "shadow_old_p");
    step(1'b1, 1'b0, 2'b00, 1'b0, 4, 0, pk(0, 1, 1, 1, 0, 1), "shadow_wrap10");
    for (int c = 1; c <= 4; c++) step(1'b1, 1'b0, 2'b00, 1'b0, 4, 0, pk(c, 1, 1, 0, 0, 1), "shadow_new_p");
    step(1'b1, 1'b0, 2'b00, 1'b0, 4, 0, pk(0, 1, 1, 1, 0, 1), "shadow_wrap4");

    // Down one-shot P=2, then re-arm with en low/high
    step(1'b0, 1'b1, 2'b01, 1'b1, 2, 0, pk(0, 1, 0, 0, 0, 0), "os_clr");
    step(1'b1, 1'b0, 2'b01, 1'b1, 2, 0, pk(2, 0, 1, 0, 1, 1), "os_load");
    step(1'b1, 1'b0, 2'b01, 1'b1, 2, 0, pk(1, 0, 1, 0, 0, 1), "os_1");
    step(1'b1, 1'b0, 2'b01, 1'b1, 2, 0, pk(0, 0, 1, 0, 0, 1), "os_0");
    step(1'b1, 1'b0, 2'b01, 1'b1, 2, 0, pk(2, 0, 1, 0, 1, 0), "os_done");
    step(1'b1, 1'b0, 2'b01, 1'b1, 2, 0, pk(2, 0, 0, 0, 0, 0), "os_frozen_a");
    step(1'b1, 1'b0, 2'b01, 1'b1, 2, 0, pk(2, 0, 0, 0, 0, 0), "os_frozen_b");
    step(1'b0, 1'b0, 2'b01, 1'b1, 2, 0, pk(2, 0, 0, 0, 0, 0), "os_en_low");
    step(1'b1, 1'b0, 2'b01, 1'b1, 2, 0, pk(1, 0, 1, 0, 0, 1), "os_rearm_1");
    step(1'b1, 1'b0, 2'b01, 1'b1, 2, 0, pk(0, 0, 1, 0, 0, 1), "os_rearm_0");
    step(1'b1, 1'b0, 2'b01, 1'b1, 2, 0, pk(2, 0, 1, 0, 1, 0), "os_rearm_done");

    // count_reset with en at count 5, then async reset mid-count
    step(1'b0, 1'b1, 2'b00, 1'b0, 10, 0, pk(0, 1, 0, 0, 0, 0), "cr_clr");
    for (int c = 1; c <= 5; c++) step(1'b1, 1'b0, 2'b00, 1'b0, 10, 0, pk(c, 1, 1, 0, 0, 1), "cr_run");
    step(1'b1, 1'b1, 2'b00, 1'b0, 10, 0, pk(0, 1, 0, 0, 0, 1), "cr_with_en");
    for (int c = 1; c <= 3; c++) step(1'b1, 1'b0, 2'b00, 1'b0, 10, 0, pk(c, 1, 1, 0, 0, 1), "cr_resume");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async", pk(0, 1, 0, 0, 0, 0));
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 2'b00, 1'b0, 10, 0, pk(0, 1, 0, 0, 0, 0), "rst_release");
    step(1'b1, 1'b0, 2'b00, 1'b0, 10, 0, pk(1, 1, 1, 0, 0, 1), "rst_first_tick");

    // Randomized configurations against the arithmetic model
    for (int r = 0; r < 24; r++) begin
      run_cfg(2'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 40, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
